// File: rtl/insn_fetch.sv
// Instruction fetch / sequencer stage feeding the cpu block.
// Owns the program counter, reads 16-bit instructions through a ready
// handshake, hands each one to the cpu with a load pulse followed by a
// start pulse, and waits for the cpu to report idle before advancing.
// A fetched HALT encoding parks the stage until reset.
module insn_fetch #(
  parameter int              ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter logic [15:0]     HALT_INSN = 16'hE000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [15:0]       cpu_in,
  output logic              cpu_load,
  output logic              cpu_s,
  input  logic              cpu_w,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [15:0]       insn_count
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_EXEC  = 3'd4,
    ST_HALT  = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_r;
  logic [ADDR_W-1:0]   pc_r;
  logic [15:0]         ir_r;
  logic [15:0]         count_r;
  logic                mem_rd_r;
  logic                cpu_load_r;
  logic                cpu_s_r;
  logic                halted_r;
  // Set on entry to EXEC: the cpu's w flag still shows the previous idle
  // state for one cycle after the start pulse, so that cycle is skipped.
  logic                first_exec_r;

  // Every output comes straight from a register; no input reaches an output
  // without passing through a flop.
  assign mem_addr   = pc_r;
  assign mem_rd     = mem_rd_r;
  assign cpu_in     = ir_r;
  assign cpu_load   = cpu_load_r;
  assign cpu_s      = cpu_s_r;
  assign pc         = pc_r;
  assign halted     = halted_r;
  assign insn_count = count_r;

  // Sequencer FSM: state, pc, instruction register, completion counter and
  // all registered handshake outputs, updated together so that each output
  // flop is loaded with the value that belongs to the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      pc_r         <= RESET_PC;
      ir_r         <= 16'h0000;
      count_r      <= 16'h0000;
      mem_rd_r     <= 1'b0;
      cpu_load_r   <= 1'b0;
      cpu_s_r      <= 1'b0;
      halted_r     <= 1'b0;
      first_exec_r <= 1'b0;
    end else begin
      // Pulses last a single cycle unless the branch below re-arms them.
      cpu_load_r <= 1'b0;
      cpu_s_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // Only start when the cpu is idle, so a fresh load never lands on
          // a cpu that is still busy.
          if (run && cpu_w) begin
            state_r  <= ST_FETCH;
            mem_rd_r <= 1'b1;
          end else begin
            state_r  <= ST_IDLE;
            mem_rd_r <= 1'b0;
          end
        end

        ST_FETCH: begin
          // Read request stays up, address fixed at pc, until data arrives.
          if (mem_ready) begin
            ir_r     <= mem_rdata;
            mem_rd_r <= 1'b0;
            if (mem_rdata == HALT_INSN) begin
              state_r  <= ST_HALT;
              halted_r <= 1'b1;
            end else begin
              state_r    <= ST_LOAD;
              cpu_load_r <= 1'b1;
            end
          end else begin
            state_r  <= ST_FETCH;
            mem_rd_r <= 1'b1;
          end
        end

        ST_LOAD: begin
          // cpu_load is high during this state; follow with the start pulse.
          state_r <= ST_START;
          cpu_s_r <= 1'b1;
        end

        ST_START: begin
          state_r      <= ST_EXEC;
          first_exec_r <= 1'b1;
        end

        ST_EXEC: begin
          if (first_exec_r) begin
            first_exec_r <= 1'b0;
            state_r      <= ST_EXEC;
          end else if (cpu_w) begin
            // Instruction retired: advance (pc and count wrap naturally).
            pc_r    <= pc_r + PC_ONE;
            count_r <= count_r + 16'd1;
            if (run) begin
              state_r  <= ST_FETCH;
              mem_rd_r <= 1'b1;
            end else begin
              state_r  <= ST_IDLE;
              mem_rd_r <= 1'b0;
            end
          end else begin
            state_r <= ST_EXEC;
          end
        end

        ST_HALT: begin
          // Terminal until reset; run and memory activity are ignored.
          state_r  <= ST_HALT;
          halted_r <= 1'b1;
          mem_rd_r <= 1'b0;
        end

        default: begin
          state_r      <= ST_IDLE;
          mem_rd_r     <= 1'b0;
          halted_r     <= 1'b0;
          first_exec_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
